// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared encodings for the multicycle RV32I controller
package riscv_mc_pkg;

    // Opcodes held in Instr[6:0]
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Controller states; the numeric values are visible on the State port
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_ALUWB   = 4'd7,
        S_EXECI   = 4'd8,
        S_JAL     = 4'd9,
        S_BEQ     = 4'd10
    } state_e;

    // ALUOp: what the controller asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes seen by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // SrcA mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // SrcB mux
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_alu_decoder.sv
// rtl/multicycle_alu_decoder.sv - maps ALUOp and instruction fields to ALUControl
module multicycle_alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Only R-type (op5=1) with funct7b5 set subtracts; addi never does
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the shared-memory RV32I datapath
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    state_e     state_q;
    state_e     state_d;
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic [1:0] alu_op;

    // State register; reset aborts any instruction and parks in FETCH at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; anything not set by a state stays 0
    always_comb begin
        state_d       = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                pc_update    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm is computed here so BEQ/JAL already have the target
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                ResultSrc     = RES_ALUOUT;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                // Jump target sits in ALUOut; PC+4 for rd is formed from OldPC
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are gated by the reset pin so nothing writes while it is low
    always_comb begin
        PCWrite  = reset & (pc_update | (branch & Zero));
        MemWrite = reset & mem_write_raw;
        IRWrite  = reset & ir_write_raw;
        RegWrite = reset & reg_write_raw;
        State    = state_q;
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LW, OP_I: ImmSrc = IMM_I;
            OP_SW:       ImmSrc = IMM_S;
            OP_BEQ:      ImmSrc = IMM_B;
            OP_JAL:      ImmSrc = IMM_J;
            default:     ImmSrc = IMM_I;
        endcase
    end

    multicycle_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [10:0] ctl;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB};

    // Instruction vector: trace nibble k (bits 4k+3:4k) is the state in cycle k
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [2:0]  len;
        logic [23:0] tr;
        logic [1:0]  imm;
        logic [2:0]  aluc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB} per state
    function automatic logic [10:0] exp_ctl(input logic [3:0] s, input logic z);
        case (s)
            4'd0:    return 11'b1_0_0_1_0_10_00_10;
            4'd1:    return 11'b0_0_0_0_0_00_01_01;
            4'd2:    return 11'b0_0_0_0_0_00_10_01;
            4'd3:    return 11'b0_1_0_0_0_00_00_00;
            4'd4:    return 11'b0_0_0_0_1_01_00_00;
            4'd5:    return 11'b0_1_1_0_0_00_00_00;
            4'd6:    return 11'b0_0_0_0_0_00_10_00;
            4'd7:    return 11'b0_0_0_0_1_00_00_00;
            4'd8:    return 11'b0_0_0_0_0_00_10_01;
            4'd9:    return 11'b1_0_0_0_0_00_01_10;
            4'd10:   return {z, 10'b0_0_0_0_00_10_00};
            default: return 11'b0;
        endcase
    endfunction

    task automatic set_vec(input int i, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [2:0] len,
                           input logic [23:0] tr, input logic [1:0] imm,
                           input logic [2:0] aluc);
        vecs[i].op   = o;
        vecs[i].f3   = f3;
        vecs[i].f7   = f7;
        vecs[i].z    = z;
        vecs[i].len  = len;
        vecs[i].tr   = tr;
        vecs[i].imm  = imm;
        vecs[i].aluc = aluc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] s;
        logic [2:0] ea;

        set_vec(0,  7'b0000011, 3'b010, 1'b0, 1'b1, 3'd5, 24'h043210, 2'b00, 3'b000); // lw, Zero=1 ignored
        set_vec(1,  7'b0100011, 3'b010, 1'b0, 1'b0, 3'd4, 24'h005210, 2'b01, 3'b000); // sw
        set_vec(2,  7'b0110011, 3'b000, 1'b0, 1'b0, 3'd4, 24'h007610, 2'b00, 3'b000); // add
        set_vec(3,  7'b0110011, 3'b000, 1'b1, 1'b1, 3'd4, 24'h007610, 2'b00, 3'b001); // sub
        set_vec(4,  7'b0110011, 3'b110, 1'b0, 1'b0, 3'd4, 24'h007610, 2'b00, 3'b011); // or
        set_vec(5,  7'b0110011, 3'b111, 1'b0, 1'b0, 3'd4, 24'h007610, 2'b00, 3'b010); // and
        set_vec(6,  7'b0110011, 3'b010, 1'b0, 1'b0, 3'd4, 24'h007610, 2'b00, 3'b101); // slt
        set_vec(7,  7'b0110011, 3'b001, 1'b0, 1'b0, 3'd4, 24'h007610, 2'b00, 3'b000); // unlisted funct3
        set_vec(8,  7'b0010011, 3'b000, 1'b1, 1'b0, 3'd4, 24'h007810, 2'b00, 3'b000); // addi, never sub
        set_vec(9,  7'b0010011, 3'b010, 1'b0, 1'b0, 3'd4, 24'h007810, 2'b00, 3'b101); // slti
        set_vec(10, 7'b1100011, 3'b000, 1'b0, 1'b1, 3'd3, 24'h000A10, 2'b10, 3'b000); // beq taken
        set_vec(11, 7'b1100011, 3'b000, 1'b0, 1'b0, 3'd3, 24'h000A10, 2'b10, 3'b000); // beq not taken
        set_vec(12, 7'b1101111, 3'b000, 1'b0, 1'b1, 3'd4, 24'h007910, 2'b11, 3'b000); // jal
        set_vec(13, 7'b1111111, 3'b000, 1'b1, 1'b1, 3'd2, 24'h000010, 2'b00, 3'b000); // unsupported

        reset    = 1'b0;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        Zero     = 1'b1;

        // Reset holds FETCH with write enables gated off
        #12;
        chk("reset state", {28'b0, State}, 32'd0);
        chk("reset ctl", {21'b0, ctl}, {21'b0, 11'b0_0_0_0_0_10_00_10});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            op       = vecs[i].op;
            funct3   = vecs[i].f3;
            funct7b5 = vecs[i].f7;
            Zero     = vecs[i].z;
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                s  = vecs[i].tr[4*k +: 4];
                ea = (s == 4'd6 || s == 4'd8) ? vecs[i].aluc :
                     (s == 4'd10) ? 3'b001 : 3'b000;
                #0;
                chk($sformatf("v%0d c%0d state", i, k), {28'b0, State}, {28'b0, s});
                chk($sformatf("v%0d c%0d ctl", i, k), {21'b0, ctl}, {21'b0, exp_ctl(s, vecs[i].z)});
                chk($sformatf("v%0d c%0d immsrc", i, k), {30'b0, ImmSrc}, {30'b0, vecs[i].imm});
                chk($sformatf("v%0d c%0d aluctl", i, k), {29'b0, ALUControl}, {29'b0, ea});
                step();
            end
            chk($sformatf("v%0d back to fetch", i), {28'b0, State}, 32'd0);
        end

        // Reset asserted between edges while in MEMWR
        op       = 7'b0100011;
        funct3   = 3'b010;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        step();
        step();
        step();
        chk("memwr state", {28'b0, State}, 32'd5);
        chk("memwr write", {31'b0, MemWrite}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort state", {28'b0, State}, 32'd0);
        chk("abort memwrite", {31'b0, MemWrite}, 32'd0);
        chk("abort ctl", {21'b0, ctl}, {21'b0, 11'b0_0_0_0_0_10_00_10});
        @(negedge clk);
        chk("held state", {28'b0, State}, 32'd0);
        reset = 1'b1;
        #1;
        chk("release irwrite", {31'b0, IRWrite}, 32'd1);
        step();
        chk("post-release state", {28'b0, State}, 32'd1);
        chk("post-release irwrite", {31'b0, IRWrite}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
